// File: rtl/alarm_pkg.sv
// Shared types and mod-60 arithmetic for the alarm front panel.
// Latency: none (declarations and pure functions only).
// Backpressure: none.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EDIT_MIN = 2'd1,
    ST_EDIT_SEC = 2'd2,
    ST_RINGING  = 2'd3
  } state_t;

  // edit_sel encodings seen by the display multiplexer
  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_MIN  = 2'b01;
  localparam logic [1:0] SEL_SEC  = 2'b10;

  // Minute/second fields are binary 0..59 and wrap at 60
  localparam logic [5:0] MAX_UNIT = 6'd59;
  localparam logic [5:0] WRAP_LO  = 6'd0;
  localparam int         UNIT_MOD = 60;

  function automatic logic [5:0] unit_inc(input logic [5:0] v);
    return (v >= MAX_UNIT) ? WRAP_LO : v + 6'd1;
  endfunction

  function automatic logic [5:0] unit_dec(input logic [5:0] v);
    return (v == WRAP_LO) ? MAX_UNIT : v - 6'd1;
  endfunction

  // Add n (< 60) to a field, modulo 60
  function automatic logic [5:0] unit_add(input logic [5:0] v, input int n);
    logic [6:0] s;
    s = {1'b0, v} + 7'(n);
    return (s >= 7'(UNIT_MOD)) ? 6'(s - 7'(UNIT_MOD)) : s[5:0];
  endfunction

  function automatic logic [1:0] sel_of(input state_t st);
    case (st)
      ST_EDIT_MIN: return SEL_MIN;
      ST_EDIT_SEC: return SEL_SEC;
      default:     return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop synchronizer -> debounced level -> 1-cycle press pulse.
// Latency: stable raw edge reaches the level 2 + DEBOUNCE_CYCLES edges later.
// Backpressure: none; presses are pulses, never held or queued.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_d;
  logic [CNT_W-1:0] r_cnt;

  // Two-flop synchronizer for the asynchronous button
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Level flips only after the input disagrees for DEBOUNCE_CYCLES straight cycles
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_level_d <= r_level;
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_level & ~r_level_d;

endmodule

// File: rtl/alarm_time_setter.sv
// Alarm front panel: debounced buttons drive the edit FSM, alarm registers and ring request.
// Latency: press applied 1 edge after its pulse; match -> ring 3 edges; all outputs registered.
// Backpressure: none. Optional ALARM_SNOOZE_EN turns an inc press while ringing into snooze.
module alarm_time_setter
  import alarm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int RING_SECONDS    = 30,
  parameter int SNOOZE_MIN      = 5
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_btn_mode,
  input  logic       i_btn_inc,
  input  logic       i_btn_dec,
  input  logic       i_sec_tick,
  input  logic [5:0] i_cur_min,
  input  logic [5:0] i_cur_sec,
  output logic [5:0] o_alarm_min,
  output logic [5:0] o_alarm_sec,
  output logic [1:0] o_edit_sel,
  output logic       o_armed,
  output logic       o_ring
);

`ifdef ALARM_SNOOZE_EN
  localparam logic SNOOZE_ON = 1'b1;
`else
  localparam logic SNOOZE_ON = 1'b0;
`endif

  localparam int RC_W = $clog2(RING_SECONDS + 1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RING_SECONDS - 1);

  logic w_p_mode, w_p_inc, w_p_dec;
  logic w_mode, w_inc, w_dec, w_any;

  state_t          r_state, w_state_nxt;
  logic [5:0]      r_alarm_min, r_alarm_sec, w_min_nxt, w_sec_nxt;
  logic            r_armed, w_armed_nxt;
  logic [RC_W-1:0] r_ring_cnt, w_ring_cnt_nxt;
  logic            r_ring;
  logic [1:0]      r_edit_sel;
  logic            r_match_q, r_match_q_d, r_trig;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .i_clock(i_clock), .i_reset(i_reset), .i_btn(i_btn_mode), .o_press(w_p_mode));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .i_clock(i_clock), .i_reset(i_reset), .i_btn(i_btn_inc), .o_press(w_p_inc));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
    .i_clock(i_clock), .i_reset(i_reset), .i_btn(i_btn_dec), .o_press(w_p_dec));

  // Same-cycle presses resolve mode > inc > dec; losers are dropped
  assign w_mode = w_p_mode;
  assign w_inc  = w_p_inc & ~w_p_mode;
  assign w_dec  = w_p_dec & ~w_p_mode & ~w_p_inc;
  assign w_any  = w_mode | w_inc | w_dec;

  // Match pipeline: registered compare, then a registered rising-edge trigger
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_match_q   <= 1'b0;
      r_match_q_d <= 1'b0;
      r_trig      <= 1'b0;
    end else begin
      r_match_q   <= (i_cur_min == r_alarm_min) && (i_cur_sec == r_alarm_sec);
      r_match_q_d <= r_match_q;
      r_trig      <= r_match_q & ~r_match_q_d;
    end
  end

  // FSM state register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_mode)                    w_state_nxt = ST_EDIT_MIN;
        else if (r_trig && r_armed)    w_state_nxt = ST_RINGING;
      end
      ST_EDIT_MIN: if (w_mode) w_state_nxt = ST_EDIT_SEC;
      ST_EDIT_SEC: if (w_mode) w_state_nxt = ST_IDLE;
      ST_RINGING: begin
        if (w_any)                                 w_state_nxt = ST_IDLE;
        else if (i_sec_tick && r_ring_cnt == RC_LAST) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM datapath: next values for alarm fields, armed flag and ring counter
  always_comb begin
    w_min_nxt      = r_alarm_min;
    w_sec_nxt      = r_alarm_sec;
    w_armed_nxt    = r_armed;
    w_ring_cnt_nxt = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_mode)     w_armed_nxt = 1'b0;
        else if (w_dec) w_armed_nxt = ~r_armed;
      end
      ST_EDIT_MIN: begin
        if (w_inc)      w_min_nxt = unit_inc(r_alarm_min);
        else if (w_dec) w_min_nxt = unit_dec(r_alarm_min);
      end
      ST_EDIT_SEC: begin
        if (w_mode)     w_armed_nxt = 1'b1;
        else if (w_inc) w_sec_nxt = unit_inc(r_alarm_sec);
        else if (w_dec) w_sec_nxt = unit_dec(r_alarm_sec);
      end
      ST_RINGING: begin
        // A press dismisses (and clears the counter) even if sec_tick lands with it
        if (w_inc && SNOOZE_ON)     w_min_nxt = unit_add(r_alarm_min, SNOOZE_MIN);
        if (!w_any && i_sec_tick)   w_ring_cnt_nxt = r_ring_cnt + RC_W'(1);
        else if (!w_any)            w_ring_cnt_nxt = r_ring_cnt;
        if (w_state_nxt != ST_RINGING) w_ring_cnt_nxt = '0;
      end
      default: ;
    endcase
  end

  // Output registers, updated alongside the state so they never glitch
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_alarm_min <= '0;
      r_alarm_sec <= '0;
      r_armed     <= 1'b0;
      r_ring_cnt  <= '0;
      r_ring      <= 1'b0;
      r_edit_sel  <= SEL_NONE;
    end else begin
      r_alarm_min <= w_min_nxt;
      r_alarm_sec <= w_sec_nxt;
      r_armed     <= w_armed_nxt;
      r_ring_cnt  <= w_ring_cnt_nxt;
      r_ring      <= (w_state_nxt == ST_RINGING);
      r_edit_sel  <= sel_of(w_state_nxt);
    end
  end

  assign o_alarm_min = r_alarm_min;
  assign o_alarm_sec = r_alarm_sec;
  assign o_armed     = r_armed;
  assign o_ring      = r_ring;
  assign o_edit_sel  = r_edit_sel;

endmodule

// File: tb/tb_alarm_time_setter.sv
// Directed bench for alarm_time_setter with a short debounce window.
// Latency: checks sampled on the falling edge, away from the active edge.
// Backpressure: not applicable.
module tb_alarm_time_setter;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode, btn_inc, btn_dec, sec_tick;
  logic [5:0] cur_min, cur_sec;
  logic [5:0] alarm_min, alarm_sec;
  logic [1:0] edit_sel;
  logic       armed, ring;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  alarm_time_setter #(
    .DEBOUNCE_CYCLES(4),
    .RING_SECONDS(30),
    .SNOOZE_MIN(5)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .i_btn_mode(btn_mode),
    .i_btn_inc(btn_inc),
    .i_btn_dec(btn_dec),
    .i_sec_tick(sec_tick),
    .i_cur_min(cur_min),
    .i_cur_sec(cur_sec),
    .o_alarm_min(alarm_min),
    .o_alarm_sec(alarm_sec),
    .o_edit_sel(edit_sel),
    .o_armed(armed),
    .o_ring(ring)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Hold the chosen buttons long enough to be accepted, then release and let it settle
  task automatic press(input logic m, input logic i, input logic d);
    btn_mode = m; btn_inc = i; btn_dec = d;
    repeat (8) @(negedge clk);
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; sec_tick = 1'b0;
    cur_min = 6'd0; cur_sec = 6'd0;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(1);

    check("rst_min",   32'(alarm_min), 0);
    check("rst_sec",   32'(alarm_sec), 0);
    check("rst_sel",   32'(edit_sel),  0);
    check("rst_armed", 32'(armed),     0);
    check("rst_ring",  32'(ring),      0);

    // Enter minute edit
    press(1, 0, 0);
    check("edit_min_sel", 32'(edit_sel), 1);

    // Bouncy inc: 10 toggles over 20 cycles, then a final stable high
    for (int i = 0; i < 10; i++) begin
      btn_inc = (i % 2 == 0);
      wait_cyc(2);
    end
    check("bounce_none", 32'(alarm_min), 0);
    btn_inc = 1'b1;
    wait_cyc(6);
    check("bounce_early", 32'(alarm_min), 0);
    wait_cyc(1);
    check("bounce_one", 32'(alarm_min), 1);
    btn_inc = 1'b0;
    wait_cyc(10);
    check("bounce_single", 32'(alarm_min), 1);

    // Minute field wraps down through 0
    press(0, 0, 1);
    check("min_dec", 32'(alarm_min), 0);
    press(0, 0, 1);
    check("min_wrap", 32'(alarm_min), 59);

    press(1, 0, 0);
    check("edit_sec_sel", 32'(edit_sel), 2);
    repeat (3) press(0, 1, 0);
    check("sec_inc3", 32'(alarm_sec), 3);
    check("sec_min_kept", 32'(alarm_min), 59);

    press(1, 0, 0);
    check("idle_sel",   32'(edit_sel), 0);
    check("idle_armed", 32'(armed),    1);

    // Ring: alarm 59:03
    cur_min = 6'd59; cur_sec = 6'd2;
    wait_cyc(5);
    check("no_ring_early", 32'(ring), 0);
    cur_sec = 6'd3;
    wait_cyc(2);
    check("ring_lat2", 32'(ring), 0);
    wait_cyc(1);
    check("ring_lat3", 32'(ring), 1);

    for (int t = 0; t < 29; t++) begin
      sec_tick = 1'b1; wait_cyc(1);
      sec_tick = 1'b0; wait_cyc(1);
    end
    check("ring_29", 32'(ring), 1);
    sec_tick = 1'b1; wait_cyc(1);
    sec_tick = 1'b0;
    check("ring_timeout", 32'(ring), 0);
    check("armed_after_timeout", 32'(armed), 1);
    wait_cyc(5);
    check("no_retrigger_held", 32'(ring), 0);

    // Ring again, then dismiss with dec
    cur_sec = 6'd2; wait_cyc(3);
    cur_sec = 6'd3; wait_cyc(3);
    check("ring_again", 32'(ring), 1);
    btn_dec = 1'b1;
    wait_cyc(6);
    check("dismiss_pending", 32'(ring), 1);
    wait_cyc(1);
    check("dismiss_ring", 32'(ring), 0);
    btn_dec = 1'b0;
    wait_cyc(8);
    check("dismiss_armed", 32'(armed), 1);
    wait_cyc(10);
    check("dismiss_no_retrig", 32'(ring), 0);

    // Simultaneous mode+inc in IDLE: mode wins, inc dropped
    press(1, 1, 0);
    check("simul_sel",   32'(edit_sel),  1);
    check("simul_min",   32'(alarm_min), 59);
    check("simul_armed", 32'(armed),     0);

    // Async reset mid seconds edit
    press(1, 0, 0);
    check("pre_rst_sel", 32'(edit_sel), 2);
    #2 rst = 1'b1;
    #1;
    check("arst_min",   32'(alarm_min), 0);
    check("arst_sec",   32'(alarm_sec), 0);
    check("arst_sel",   32'(edit_sel),  0);
    check("arst_armed", 32'(armed),     0);
    check("arst_ring",  32'(ring),      0);
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(2);

`ifdef ALARM_SNOOZE_EN
    // Snooze: alarm 58:00 ringing, inc pushes minutes to 03
    press(1, 0, 0);
    press(0, 0, 1);
    press(0, 0, 1);
    press(1, 0, 0);
    press(1, 0, 0);
    check("snz_setup_min", 32'(alarm_min), 58);
    check("snz_setup_armed", 32'(armed), 1);
    cur_min = 6'd57; cur_sec = 6'd59; wait_cyc(3);
    cur_min = 6'd58; cur_sec = 6'd0;  wait_cyc(3);
    check("snz_ring", 32'(ring), 1);
    press(0, 1, 0);
    check("snz_min",   32'(alarm_min), 3);
    check("snz_sec",   32'(alarm_sec), 0);
    check("snz_ring_off", 32'(ring),   0);
    check("snz_armed", 32'(armed),     1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/alarm_time_setter.md
# alarm_time_setter

Front-panel input block for the alarm clock. It takes the three raw push-buttons, synchronizes and debounces them, and runs the edit state machine that writes the alarm minute and second registers. It compares the running time against the alarm time and drives the ring request into the song player. It is the writer side of the time/display path: the display multiplexer and the song player only consume its outputs.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000, consecutive stable clock cycles needed to accept a button level change (10 ms at 100 MHz).
- `RING_SECONDS`, 30, number of `sec_tick` pulses after which ringing self-terminates.
- `SNOOZE_MIN`, 5, minutes added on snooze (only with the snooze macro).
- `clock`  in  1  system clock, 100 MHz.
- `reset`  in  1  asynchronous, active-high; all state returns to reset values immediately.
- `btn_mode`, `btn_inc`, `btn_dec`  in  1 each  raw, asynchronous, active-high buttons.
- `sec_tick`  in  1  single-cycle pulse, once per second.
- `cur_min`, `cur_sec`  in  6 each  running time, binary 0–59.
- `alarm_min`, `alarm_sec`  out  6 each  alarm time, binary 0–59; reset value 0 / 0.
- `edit_sel`  out  2  00 = not editing, 01 = minutes, 10 = seconds; reset value 00.
- `armed`  out  1  alarm enabled; reset value 0.
- `ring`  out  1  level; connects to the song player's `playSound`; reset value 0.

## Operation
- Per button: 2-flop synchronizer, then a debounce counter. The debounced level flips only after the synchronized input differs from it for `DEBOUNCE_CYCLES` consecutive cycles. Any bounce restarts the count. A rising edge of the debounced level produces a 1-cycle press pulse.
- Simultaneous pulses in the same cycle: priority mode > inc > dec. Lower-priority pulses are dropped.
- FSM states are IDLE, EDIT_MIN, EDIT_SEC and RINGING.
- IDLE:
  - mode press → EDIT_MIN, which clears `armed`.
  - dec press toggles `armed`.
  - inc press is ignored.
- EDIT_MIN / EDIT_SEC:
  - inc adds 1 to the selected field; 59 wraps to 0.
  - dec subtracts 1; 0 wraps to 59.
  - No carry between fields.
  - mode press moves EDIT_MIN → EDIT_SEC, and EDIT_SEC → IDLE with `armed` set to 1.
- Match detection:
  - `match` = (`cur_min` == `alarm_min`) && (`cur_sec` == `alarm_sec`), registered as `match_q`.
  - Trigger = `match_q` && !`match_q_d`, i.e. the rising edge only.
  - A trigger while in IDLE with `armed` = 1 → RINGING.
  - A dismissal inside the matching second does not re-trigger.
  - Matches during editing are ignored.
- RINGING:
  - `ring` = 1.
  - Each `sec_tick` increments the ring counter. When it reaches `RING_SECONDS` → IDLE, with `armed` unchanged.
  - Any press pulse → IDLE. The press is consumed: no edit or arm toggle occurs. `armed` stays 1.
- Reset mid-edit or mid-ring: IDLE, registers 0, `armed` 0, `ring` 0, debounce counters and debounced levels 0.

## Timing
- Press latency: a raw edge held stable is accepted 2 + `DEBOUNCE_CYCLES` cycles later; the press pulse lasts 1 cycle; the register/state update is visible on the following edge.
- Alarm latency: `cur_*` reaching a match → `ring` high 3 edges later (`match_q`, edge detect, state).
- `ring` is a registered output. It drops on the edge after the dismissing pulse or the final `sec_tick`.
- `sec_tick` and a press in the same RINGING cycle: the press wins, and the ring counter is cleared.
- All outputs are registered and glitch-free.

## Configuration
- `ALARM_SNOOZE_EN` defined:
  - In RINGING, an inc press → IDLE with `alarm_min` = (`alarm_min` + `SNOOZE_MIN`) mod 60.
  - `alarm_sec` is unchanged and `armed` stays 1.
  - mode/dec presses dismiss as normal.
- `ALARM_SNOOZE_EN` not defined: inc dismisses exactly like the other buttons, and `SNOOZE_MIN` is unused.

## Structure
- Package `alarm_pkg` holds:
  - the FSM state enum;
  - `edit_sel` encodings;
  - `MAX_UNIT` = 59;
  - the mod-60 wrap constants, shared with the seconds/minutes counters.
- Sub-module `btn_debounce` (synchronizer + debounce + press pulse), instantiated three times. The FSM, compare and ring counter live in the top module.

## Test plan
All cases use `DEBOUNCE_CYCLES` = 4.
- Bounce: toggle `btn_inc` every 2 cycles for 20 cycles, then hold → exactly one increment, at 2+4+1 cycles after the final edge.
- Edit and wrap:
  - mode, then dec ×1 → `alarm_min` = 59.
  - mode, then inc ×3 → `alarm_sec` = 3.
  - mode → IDLE with `armed` = 1 and `edit_sel` = 00.
- Ring:
  - armed alarm 59:03; drive `cur` 59:02 → 59:03 → `ring` high 3 cycles later.
  - 30 `sec_tick` pulses → `ring` low, `armed` still 1.
- Dismiss and no re-trigger: while ringing, press dec → `ring` low. Holding `cur` at 59:03 for 10 more cycles → `ring` stays low.
- Simultaneous press and reset:
  - mode+inc pressed together in IDLE → only EDIT_MIN entered, `alarm_min` unchanged.
  - assert `reset` mid-EDIT_SEC → all outputs 0 the same cycle.
- With `ALARM_SNOOZE_EN`: alarm 58:00 ringing, press inc → `alarm_min` = 3, `ring` low, `armed` 1.
